// File: rtl/mips_io_pkg.sv
// Shared definitions for the memory-mapped MIPS I/O controller:
// register offsets, port-count limit and the register-select encoding.
package mips_io_pkg;

    localparam logic [7:0] OFF_OUT    = 8'h00;
    localparam logic [7:0] OFF_IN     = 8'h40;
    localparam logic [7:0] OFF_STATUS = 8'h80;
    localparam logic [7:0] OFF_MASK   = 8'h84;

    localparam int MAX_PORTS   = 16;
    localparam int WINDOW_BITS = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_IN,
        SEL_STATUS,
        SEL_MASK
    } reg_sel_e;

    // Word index of a register inside the OUT or IN bank.
    function automatic logic [3:0] bank_index(input logic [7:0] offset);
        return offset[5:2];
    endfunction

endpackage

// File: rtl/io_input_sync.sv
// One input port: two-flop synchroniser plus a previous-value stage.
// o_change flags any bit difference between the synchronised and previous value.
module io_input_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_port,
    output logic [WIDTH-1:0] o_sync,
    output logic             o_change
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_port;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync   = r_s2;
    assign o_change = |(r_s2 ^ r_s3);

endmodule

// File: rtl/mips_io_controller.sv
// Memory-mapped GPIO block on the MIPS data bus: output latches, synchronised
// inputs, sticky change flags with W1C clear, and a masked level interrupt.
module mips_io_controller
    import mips_io_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          PORT_WIDTH = 8,
    parameter int          NUM_IN     = 2,
    parameter int          NUM_OUT    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   Address,
    input  logic [DATA_WIDTH-1:0]         WriteData,
    input  logic                          MemWrite,
    input  logic                          MemRead,
    output logic [DATA_WIDTH-1:0]         ReadData,
    output logic                          Hit,
    input  logic [NUM_IN*PORT_WIDTH-1:0]  PortIn,
    output logic [NUM_OUT*PORT_WIDTH-1:0] PortOut,
    output logic                          Irq
);

    logic [PORT_WIDTH-1:0] r_out [NUM_OUT];
    logic [NUM_IN-1:0]     r_mask;
    logic [NUM_IN-1:0]     r_status;

    logic [PORT_WIDTH-1:0] w_in_sync [NUM_IN];
    logic [NUM_IN-1:0]     w_change;
    logic [31:0]           w_offset;
    logic [3:0]            w_idx;
    reg_sel_e              w_sel;
    logic                  w_wr;
    logic [NUM_IN-1:0]     w_clr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_in
            io_input_sync #(.WIDTH(PORT_WIDTH)) u_sync (
                .clk      (clk),
                .rst_n    (reset),
                .i_port   (PortIn[g*PORT_WIDTH +: PORT_WIDTH]),
                .o_sync   (w_in_sync[g]),
                .o_change (w_change[g])
            );
        end
        for (g = 0; g < NUM_OUT; g++) begin : g_out
            assign PortOut[g*PORT_WIDTH +: PORT_WIDTH] = r_out[g];
        end
    endgenerate

    // Subtracting the base makes any address below the window wrap far out of range.
    assign w_offset = Address - BASE_ADDR;
    assign w_idx    = bank_index(w_offset[7:0]);

    always_comb begin
        w_sel = SEL_NONE;
        if (w_offset[31:WINDOW_BITS] == '0 && w_offset[1:0] == 2'b00) begin
            if (w_offset[7:6] == OFF_OUT[7:6]) begin
                if (int'(w_idx) < NUM_OUT) w_sel = SEL_OUT;
            end else if (w_offset[7:6] == OFF_IN[7:6]) begin
                if (int'(w_idx) < NUM_IN) w_sel = SEL_IN;
            end else if (w_offset[7:0] == OFF_STATUS) begin
                w_sel = SEL_STATUS;
            end else if (w_offset[7:0] == OFF_MASK) begin
                w_sel = SEL_MASK;
            end
        end
    end

    assign Hit   = (w_sel != SEL_NONE);
    assign w_wr  = MemWrite && Hit;
    assign w_clr = (w_wr && w_sel == SEL_STATUS) ? WriteData[NUM_IN-1:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
            r_mask   <= '0;
            r_status <= '0;
        end else begin
            if (w_wr && w_sel == SEL_OUT) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (w_idx == 4'(i)) r_out[i] <= WriteData[PORT_WIDTH-1:0];
                end
            end
            if (w_wr && w_sel == SEL_MASK) r_mask <= WriteData[NUM_IN-1:0];
            // A fresh change beats a simultaneous clear so no edge is lost.
            r_status <= (r_status & ~w_clr) | w_change;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (MemRead && Hit) begin
            case (w_sel)
                SEL_OUT: begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (w_idx == 4'(i)) w_rdata[PORT_WIDTH-1:0] = r_out[i];
                    end
                end
                SEL_IN: begin
                    for (int j = 0; j < NUM_IN; j++) begin
                        if (w_idx == 4'(j)) w_rdata[PORT_WIDTH-1:0] = w_in_sync[j];
                    end
                end
                SEL_STATUS: w_rdata[NUM_IN-1:0] = r_status;
                SEL_MASK:   w_rdata[NUM_IN-1:0] = r_mask;
                default:    w_rdata = '0;
            endcase
        end
    end

    assign ReadData = w_rdata;
    assign Irq      = |(r_status & r_mask);

    assign w_unused = ^WriteData;

endmodule

// File: doc/mips_io_controller.md
MIPS_IO_CONTROLLER -- requirements
Module: mips_io_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-002 SHALL have parameter PORT_WIDTH, default 8, width of each I/O port; legal range 1..DATA_WIDTH.
REQ-003 SHALL have parameter NUM_IN, default 2, number of input ports; legal range 1..16.
REQ-004 SHALL have parameter NUM_OUT, default 2, number of output ports; legal range 1..16.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h1001_0000, word-aligned base of the register window.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port Address, input, 32, byte address from the ALU result.
REQ-010 SHALL have port WriteData, input, DATA_WIDTH, store data from register file port 2.
REQ-011 SHALL have port MemWrite, input, 1, store strobe.
REQ-012 SHALL have port MemRead, input, 1, load strobe.
REQ-013 SHALL have port ReadData, output, DATA_WIDTH, load data, combinational.
REQ-014 SHALL have port Hit, output, 1, Address decodes inside the window, combinational.
REQ-015 SHALL have port PortIn, input, NUM_IN*PORT_WIDTH, asynchronous external inputs; port j occupies bits [j*PORT_WIDTH +: PORT_WIDTH].
REQ-016 SHALL have port PortOut, output, NUM_OUT*PORT_WIDTH, registered external outputs.
REQ-017 SHALL have port Irq, output, 1, level interrupt request.

Function
REQ-018 SHALL use this register map (offsets from BASE_ADDR): OUT[i] at 0x00+4i (read/write); IN[j] at 0x40+4j (read-only); STATUS at 0x80 (bit j = change flag of IN[j], write-1-to-clear); MASK at 0x84 (bit j = interrupt enable of IN[j], read/write).
REQ-019 SHALL assert Hit only for a word-aligned Address (Address[1:0]==0) that matches an implemented register; an unimplemented index, a misaligned address or an out-of-window address SHALL give Hit=0.
REQ-020 SHALL, when MemWrite=1 and Hit=1, update the addressed writable register at the next rising clk edge with WriteData[PORT_WIDTH-1:0] (OUT) or WriteData[NUM_IN-1:0] (MASK); upper bits are ignored.
REQ-021 SHALL ignore writes to IN registers and all writes with Hit=0.
REQ-022 SHALL drive ReadData to the zero-extended addressed register when MemRead=1 and Hit=1, and to 0 otherwise.
REQ-023 SHALL pass each PortIn bit through a two-flop synchroniser; IN[j] reads the second stage, so an input change set up before edge k becomes readable after edge k+1.
REQ-024 SHALL keep a third (previous) stage per input and set STATUS[j] at edge k+2 whenever stage 2 differs from stage 3 in any bit of port j.
REQ-025 SHALL keep STATUS bits sticky until cleared by writing 1 to them; writing 0 has no effect.
REQ-026 SHALL give set priority when a new change and a W1C clear of the same bit occur in the same cycle, so the bit remains 1.
REQ-027 SHALL drive Irq = OR over j of (STATUS[j] AND MASK[j]), combinational from registered state.
REQ-028 SHALL drive PortOut directly from the OUT registers, with no combinational path from any input.

Reset
REQ-029 SHALL, on reset low, asynchronously clear all OUT, MASK, STATUS and synchroniser flops to 0, so that PortOut=0 and Irq=0.
REQ-030 SHALL hold all state at 0 while reset is low, and SHALL ignore bus writes while reset is low.
REQ-031 SHALL set STATUS[j] at the third edge after reset release if PortIn port j is non-zero; this is defined behaviour and software clears it.

Structure
REQ-032 SHALL place the register offsets (0x00, 0x40, 0x80, 0x84) and the maximum port count in the shared package mips_io_pkg.
REQ-033 SHALL implement the synchroniser and change detection of one input port in the sub-module io_input_sync, instantiated NUM_IN times by a generate loop.

Verification
REQ-034 Write 32'hA5 to BASE+0x04 -> PortOut[15:8]=8'hA5 after the next edge and PortOut[7:0] unchanged; a read of BASE+0x04 returns 32'h0000_00A5.
REQ-035 Drive PortIn[7:0]=8'h3C before edge k -> a read of BASE+0x40 returns 0x3C from edge k+1; STATUS[0]=1 from edge k+2.
REQ-036 With MASK=2'b01 and STATUS[0]=1 -> Irq=1; write 1 to STATUS bit 0 at BASE+0x80 -> STATUS[0]=0 and Irq=0 after the edge.
REQ-037 A new change on IN[0] in the same cycle as its W1C write -> STATUS[0] stays 1.
REQ-038 Access BASE+0x42, BASE+0x48 (with NUM_IN=2) and BASE+0x100 -> Hit=0, ReadData=0, no register changes.
REQ-039 Assert reset asynchronously mid-cycle with OUT[0]=0xFF and MASK=3 -> PortOut=0 and Irq=0 immediately, without waiting for a clk edge.
